// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: minutes/seconds registers, run/pause/clear/adjust FSM.
// Optional blink masking of the field being adjusted is enabled by defining STOPWATCH_CTRL_BLINK_EN.
module stopwatch_ctrl #(
    parameter int W       = 6,
    parameter int MAX_SEC = 59,
    parameter int MAX_MIN = 59
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tick_1hz,
    input  logic         tick_2hz,
    input  logic         tick_blink,
    input  logic         pause_p,
    input  logic         clear_p,
    input  logic         sel,
    input  logic         adj,
    output logic [W-1:0] minutes,
    output logic [W-1:0] seconds,
    output logic         running,
    output logic         rollover,
    output logic [1:0]   blink_mask
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_ADJ   = 2'd3;

    localparam logic [W-1:0] SEC_MAX = W'(MAX_SEC);
    localparam logic [W-1:0] MIN_MAX = W'(MAX_MIN);

    // Anything at or above the field maximum (including forced out-of-range values) wraps to 0.
    function automatic logic [W-1:0] wrap_inc(input logic [W-1:0] v, input logic [W-1:0] max_v);
        if (v >= max_v) begin
            return '0;
        end
        return W'(v + 1'b1);
    endfunction

    logic [1:0]   state, state_nxt;
    logic [1:0]   saved_state, saved_nxt;
    logic [W-1:0] min_nxt, sec_nxt;
    logic         roll_nxt;
    logic [1:0]   blink_nxt;

    always_comb begin
        state_nxt = state;
        saved_nxt = saved_state;
        min_nxt   = minutes;
        sec_nxt   = seconds;
        roll_nxt  = 1'b0;
        blink_nxt = 2'b00;

        if (clear_p) begin
            min_nxt = '0;
            sec_nxt = '0;
            if (adj) begin
                state_nxt = S_ADJ;
                saved_nxt = S_IDLE;
            end else begin
                state_nxt = S_IDLE;
            end
        end else if (adj) begin
            if (state != S_ADJ) begin
                saved_nxt = state;
                state_nxt = S_ADJ;
            end
            if (tick_2hz) begin
                if (sel) begin
                    sec_nxt = wrap_inc(seconds, SEC_MAX);
                end else begin
                    min_nxt = wrap_inc(minutes, MIN_MAX);
                end
            end
`ifdef STOPWATCH_CTRL_BLINK_EN
            blink_nxt = sel ? {1'b0, blink_mask[0]} : {blink_mask[1], 1'b0};
            if (tick_2hz) begin
                blink_nxt = 2'b00;
            end else if (tick_blink) begin
                blink_nxt = blink_nxt ^ (sel ? 2'b01 : 2'b10);
            end
`endif
        end else if (state == S_ADJ) begin
            // A cleared watch that was adjusted to a nonzero time parks in PAUSE so pause_p resumes it.
            if (saved_state == S_IDLE) begin
                state_nxt = ((minutes != '0) || (seconds != '0)) ? S_PAUSE : S_IDLE;
            end else begin
                state_nxt = saved_state;
            end
        end else begin
            if (pause_p) begin
                case (state)
                    S_IDLE:  state_nxt = S_RUN;
                    S_RUN:   state_nxt = S_PAUSE;
                    S_PAUSE: state_nxt = S_RUN;
                    default: state_nxt = state;
                endcase
            end
            if ((state == S_RUN) && tick_1hz) begin
                if (seconds >= SEC_MAX) begin
                    sec_nxt = '0;
                    if (minutes >= MIN_MAX) begin
                        min_nxt  = '0;
                        roll_nxt = 1'b1;
                    end else begin
                        min_nxt = wrap_inc(minutes, MIN_MAX);
                    end
                end else begin
                    sec_nxt = wrap_inc(seconds, SEC_MAX);
                end
            end
        end
    end

`ifndef STOPWATCH_CTRL_BLINK_EN
    logic unused_tick_blink;
    assign unused_tick_blink = tick_blink;
`else
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            saved_state <= S_IDLE;
            minutes     <= '0;
            seconds     <= '0;
            running     <= 1'b0;
            rollover    <= 1'b0;
            blink_mask  <= 2'b00;
        end else begin
            state       <= state_nxt;
            saved_state <= saved_nxt;
            minutes     <= min_nxt;
            seconds     <= sec_nxt;
            running     <= (state_nxt == S_RUN);
            rollover    <= roll_nxt;
            blink_mask  <= blink_nxt;
        end
    end

endmodule
